// File: rtl/rob_mp.sv
// Multi-port reorder buffer: in-order allocation, out-of-order writeback, in-order retirement.
// Optional dual commit is enabled by defining ROB_DUAL_COMMIT_EN.
module rob_mp #(
  parameter int ARCH_BITS    = 32,
  parameter int REG_IDX_BITS = 5,
  parameter int SLOTS        = 16,
  parameter int IDX_BITS     = 4,
  parameter int WB_PORTS     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             allocReq,
  input  logic [ARCH_BITS-1:0]             allocPc,
  output logic                             allocReady,
  output logic [IDX_BITS-1:0]              allocIdx,
  output logic [IDX_BITS:0]                count,
  output logic                             empty,
  input  logic [WB_PORTS-1:0]              wbValid,
  input  logic [WB_PORTS*IDX_BITS-1:0]     wbIdx,
  input  logic [WB_PORTS-1:0]              wbExcept,
  input  logic [WB_PORTS*ARCH_BITS-1:0]    wbAddress,
  input  logic [WB_PORTS*ARCH_BITS-1:0]    wbData,
  input  logic [WB_PORTS*REG_IDX_BITS-1:0] wbDst,
  input  logic [WB_PORTS-1:0]              wbWe,
  output logic                             except,
  output logic [ARCH_BITS-1:0]             address,
  output logic [ARCH_BITS-1:0]             pc,
  output logic                             wEnable,
  output logic [REG_IDX_BITS-1:0]          wDstReg,
  output logic [ARCH_BITS-1:0]             wData,
  output logic                             wEnable2,
  output logic [REG_IDX_BITS-1:0]          wDstReg2,
  output logic [ARCH_BITS-1:0]             wData2
);

  localparam logic [IDX_BITS:0] FULL = (IDX_BITS+1)'(SLOTS);

  logic [SLOTS-1:0]        busy_reg, done_reg, exc_reg;
  logic [IDX_BITS-1:0]     head_reg, tail_reg;
  logic [IDX_BITS:0]       count_reg;

  logic [ARCH_BITS-1:0]    pc_mem   [SLOTS];
  logic [ARCH_BITS-1:0]    addr_mem [SLOTS];
  logic [ARCH_BITS-1:0]    data_mem [SLOTS];
  logic [REG_IDX_BITS-1:0] dst_mem  [SLOTS];
  logic [SLOTS-1:0]        we_mem;

  logic [IDX_BITS-1:0]     wb_idx  [WB_PORTS];
  logic [ARCH_BITS-1:0]    wb_addr [WB_PORTS];
  logic [ARCH_BITS-1:0]    wb_data [WB_PORTS];
  logic [REG_IDX_BITS-1:0] wb_dst  [WB_PORTS];

  genvar gi;
  generate
    for (gi = 0; gi < WB_PORTS; gi++) begin : g_unpack
      assign wb_idx[gi]  = wbIdx[gi*IDX_BITS +: IDX_BITS];
      assign wb_addr[gi] = wbAddress[gi*ARCH_BITS +: ARCH_BITS];
      assign wb_data[gi] = wbData[gi*ARCH_BITS +: ARCH_BITS];
      assign wb_dst[gi]  = wbDst[gi*REG_IDX_BITS +: REG_IDX_BITS];
    end
  endgenerate

  logic                head_ret, head_exc, flushing, commit0, commit1, alloc_fire;
  logic [IDX_BITS-1:0] head_nxt;

  assign head_nxt   = head_reg + IDX_BITS'(1);
  assign head_ret   = busy_reg[head_reg] & done_reg[head_reg];
  assign head_exc   = head_ret & exc_reg[head_reg];
  assign flushing   = head_exc | clear;
  assign commit0    = head_ret & ~exc_reg[head_reg] & ~clear;
  assign allocReady = (count_reg != FULL) & ~flushing;
  assign alloc_fire = allocReq & allocReady;
  assign allocIdx   = tail_reg;
  assign count      = count_reg;
  assign empty      = (count_reg == '0);

  assign except   = head_exc & ~clear;
  assign pc       = pc_mem[head_reg];
  assign address  = addr_mem[head_reg];
  assign wEnable  = commit0 & we_mem[head_reg];
  assign wDstReg  = dst_mem[head_reg];
  assign wData    = data_mem[head_reg];

`ifdef ROB_DUAL_COMMIT_EN
  // A second entry may only retire alongside a clean head retirement.
  assign commit1  = commit0 & busy_reg[head_nxt] & done_reg[head_nxt] & ~exc_reg[head_nxt];
  assign wEnable2 = commit1 & we_mem[head_nxt];
  assign wDstReg2 = dst_mem[head_nxt];
  assign wData2   = data_mem[head_nxt];
`else
  assign commit1  = 1'b0;
  assign wEnable2 = 1'b0;
  assign wDstReg2 = '0;
  assign wData2   = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg  <= '0;
      done_reg  <= '0;
      exc_reg   <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flushing) begin
      busy_reg  <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      // Later ports overwrite earlier ones on a collision.
      for (int k = 0; k < WB_PORTS; k++) begin
        if (wbValid[k] && busy_reg[wb_idx[k]]) begin
          done_reg[wb_idx[k]] <= 1'b1;
          exc_reg[wb_idx[k]]  <= wbExcept[k];
        end
      end
      if (commit0) busy_reg[head_reg] <= 1'b0;
      if (commit1) busy_reg[head_nxt] <= 1'b0;
      if (alloc_fire) begin
        busy_reg[tail_reg] <= 1'b1;
        done_reg[tail_reg] <= 1'b0;
        exc_reg[tail_reg]  <= 1'b0;
        tail_reg           <= tail_reg + IDX_BITS'(1);
      end
      head_reg  <= head_reg + IDX_BITS'(commit0) + IDX_BITS'(commit1);
      count_reg <= count_reg + (IDX_BITS+1)'(alloc_fire)
                   - (IDX_BITS+1)'(commit0) - (IDX_BITS+1)'(commit1);
    end
  end

  // Payload storage carries no reset; busy/done gate every use of it.
  always_ff @(posedge clk) begin
    if (!flushing) begin
      for (int k = 0; k < WB_PORTS; k++) begin
        if (wbValid[k] && busy_reg[wb_idx[k]]) begin
          addr_mem[wb_idx[k]] <= wb_addr[k];
          data_mem[wb_idx[k]] <= wb_data[k];
          dst_mem[wb_idx[k]]  <= wb_dst[k];
          we_mem[wb_idx[k]]   <= wbWe[k];
        end
      end
      if (alloc_fire) pc_mem[tail_reg] <= allocPc;
    end
  end

endmodule

// File: tb/tb_rob_mp.sv
// Randomised scoreboard bench for rob_mp against a queue-based program-order model.
module tb_rob_mp;
  localparam int AB = 32, RB = 5, SLOTS = 16, IB = 4, WP = 4;

  logic            clk = 1'b0, rst = 1'b1, clear = 1'b0;
  logic            allocReq = 1'b0;
  logic [AB-1:0]   allocPc = '0;
  logic            allocReady;
  logic [IB-1:0]   allocIdx;
  logic [IB:0]     count;
  logic            empty;
  logic [WP-1:0]   wbValid = '0, wbExcept = '0, wbWe = '0;
  logic [WP*IB-1:0] wbIdx = '0;
  logic [WP*AB-1:0] wbAddress = '0, wbData = '0;
  logic [WP*RB-1:0] wbDst = '0;
  logic            except, wEnable, wEnable2;
  logic [AB-1:0]   address, pc, wData, wData2;
  logic [RB-1:0]   wDstReg, wDstReg2;

  rob_mp #(.ARCH_BITS(AB), .REG_IDX_BITS(RB), .SLOTS(SLOTS), .IDX_BITS(IB), .WB_PORTS(WP)) dut (
    .clk(clk), .rst(rst), .clear(clear), .allocReq(allocReq), .allocPc(allocPc),
    .allocReady(allocReady), .allocIdx(allocIdx), .count(count), .empty(empty),
    .wbValid(wbValid), .wbIdx(wbIdx), .wbExcept(wbExcept), .wbAddress(wbAddress),
    .wbData(wbData), .wbDst(wbDst), .wbWe(wbWe), .except(except), .address(address),
    .pc(pc), .wEnable(wEnable), .wDstReg(wDstReg), .wData(wData),
    .wEnable2(wEnable2), .wDstReg2(wDstReg2), .wData2(wData2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx; logic [31:0] pc, addr, data; logic [4:0] dst; bit done, exc, we;
  } ent_t;
  typedef struct { int kind; logic [31:0] a, b; } ev_t;  // kind 0/1: commit port, 2: exception

  ent_t q[$];
  ev_t  sb[$];
  int   tail_m = 0;
  int   pass_cnt = 0, total_cnt = 0, events_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: cycle outcome computed from the program-order entry list.
  task automatic model_step();
    bit ret, hexc, flush, rdy, alloc_ok, dual;
    int n;
    ret   = q.size() > 0 && q[0].done;
    hexc  = ret && q[0].exc;
    flush = hexc || clear;
    rdy   = q.size() < SLOTS && !flush;
    chk("allocReady", 32'(allocReady), 32'(rdy));
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    if (rdy) chk("allocIdx", 32'(allocIdx), 32'(tail_m));
    if (flush) begin
      if (!clear) sb.push_back('{2, q[0].pc, q[0].addr});
      q.delete();
      tail_m = 0;
      $display("cycle: flush (clear=%0b exc=%0b)", clear, hexc);
      return;
    end
    alloc_ok = allocReq && rdy;
    n = 0;
    if (ret) begin
      n = 1;
      if (q[0].we) sb.push_back('{0, 32'(q[0].dst), q[0].data});
`ifdef ROB_DUAL_COMMIT_EN
      dual = q.size() > 1 && q[1].done && !q[1].exc;
      if (dual) begin
        n = 2;
        if (q[1].we) sb.push_back('{1, 32'(q[1].dst), q[1].data});
      end
`else
      dual = 0;
`endif
    end
    for (int p = 0; p < WP; p++) begin
      if (wbValid[p]) begin
        for (int i = 0; i < q.size(); i++) begin
          if (q[i].idx == int'(wbIdx[p*IB +: IB])) begin
            q[i].done = 1; q[i].exc = wbExcept[p]; q[i].we = wbWe[p];
            q[i].data = wbData[p*AB +: AB]; q[i].addr = wbAddress[p*AB +: AB];
            q[i].dst  = wbDst[p*RB +: RB];
          end
        end
      end
    end
    for (int i = 0; i < n; i++) void'(q.pop_front());
    if (alloc_ok) begin
      q.push_back('{tail_m, allocPc, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0});
      tail_m = (tail_m + 1) % SLOTS;
    end
    $display("cycle: alloc=%0b retire=%0d wb=%b occ=%0d", alloc_ok, n, wbValid, q.size());
  endtask

  task automatic do_cycle(input int p_alloc, input int p_wb, input int p_exc, input int p_clr);
    int sel;
    @(negedge clk);
    allocReq = $urandom_range(99) < p_alloc;
    allocPc  = $urandom;
    clear    = $urandom_range(99) < p_clr;
    for (int p = 0; p < WP; p++) begin
      wbValid[p]  = $urandom_range(99) < p_wb;
      wbExcept[p] = $urandom_range(99) < p_exc;
      wbWe[p]     = $urandom_range(3) != 0;
      if (q.size() > 0 && $urandom_range(3) != 0) begin
        sel = $urandom_range(q.size() - 1);
        wbIdx[p*IB +: IB] = IB'(q[sel].idx);
      end else begin
        wbIdx[p*IB +: IB] = IB'($urandom_range(SLOTS - 1));
      end
      wbData[p*AB +: AB]    = $urandom;
      wbAddress[p*AB +: AB] = $urandom;
      wbDst[p*RB +: RB]     = RB'($urandom);
    end
    #1 model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    allocReq = 0; wbValid = '0; clear = 0; rst = 1;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_allocReady", 32'(allocReady), 32'd1);
    chk("rst_allocIdx", 32'(allocIdx), 32'd0);
    chk("rst_wEnable", 32'(wEnable), 32'd0);
    chk("rst_except", 32'(except), 32'd0);
    q.delete(); tail_m = 0;
    $display("cycle: reset");
    #2 rst = 0;
  endtask

  // Monitor: pops an expected event whenever the DUT presents one.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      #2;
      if (except) begin
        events_seen++;
        if (sb.size() == 0) chk("unexpected_except", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("except_kind", 32'd2, 32'(e.kind));
          chk("except_pc", pc, e.a);
          chk("except_address", address, e.b);
          chk("except_wEnable", 32'(wEnable), 32'd0);
        end
      end
      if (wEnable) begin
        events_seen++;
        if (sb.size() == 0) chk("unexpected_wEnable", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("commit0_kind", 32'd0, 32'(e.kind));
          chk("commit0_dst", 32'(wDstReg), e.a);
          chk("commit0_data", wData, e.b);
        end
      end
      if (wEnable2) begin
        events_seen++;
        if (sb.size() == 0) chk("unexpected_wEnable2", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("commit1_kind", 32'd1, 32'(e.kind));
          chk("commit1_dst", 32'(wDstReg2), e.a);
          chk("commit1_data", wData2, e.b);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (5)   do_cycle(100, 0, 0, 0);
    do_reset();
    repeat (20)  do_cycle(100, 0, 0, 0);
    repeat (300) do_cycle(70, 30, 0, 0);
    repeat (300) do_cycle(60, 40, 5, 2);
    repeat (200) do_cycle(50, 60, 0, 0);
    repeat (60)  do_cycle(0, 60, 0, 0);
    @(negedge clk);
    allocReq = 0; wbValid = '0; clear = 0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    total_cnt++;
    if (events_seen > 0) pass_cnt++;
    else $display("FAIL events_seen: got 0 expected nonzero");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
